// File: rtl/aes_timing_pkg.sv
// Shared constants and write-FSM state type for the AES input/output timing blocks.
package aes_timing_pkg;
  localparam int WORD_W        = 32;
  localparam int WORDS_PER_BLK = 4;
  localparam int DEPTH_BLK     = 2;
  localparam int FRAME_PERIOD  = 40;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DROP    = 2'd2
  } wr_state_e;
endpackage

// File: rtl/out_store_timing_blk_buffer.sv
// Block storage: DEPTH x WPB words, owns the block pointers and the committed-block count.
module blk_buffer #(
  parameter int W     = aes_timing_pkg::WORD_W,
  parameter int WPB   = aes_timing_pkg::WORDS_PER_BLK,
  parameter int DEPTH = aes_timing_pkg::DEPTH_BLK,
  localparam int IDX_W = $clog2(WPB),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [W-1:0]     wr_data,
  input  logic             commit,
  input  logic             free,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [W-1:0]     rd_data,
  output logic [CNT_W-1:0] blk_count
);
  logic [W-1:0]     mem_q [DEPTH*WPB];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = commit ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = free ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + {{(CNT_W-1){1'b0}}, commit} - {{(CNT_W-1){1'b0}}, free};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Partial blocks are written straight into the free slot; only commit makes them visible.
  always_ff @(posedge clk) begin
    if (we) mem_q[{wr_ptr_q, wr_idx}] <= wr_data;
  end

  assign rd_data   = mem_q[{rd_ptr_q, rd_idx}];
  assign blk_count = count_q;
endmodule

// File: rtl/out_store_timing.sv
// Assembles ciphertext columns into blocks, drains them word-by-word, flags core-side faults.
module out_store_timing #(
  parameter int WORD_W        = aes_timing_pkg::WORD_W,
  parameter int WORDS_PER_BLK = aes_timing_pkg::WORDS_PER_BLK,
  parameter int DEPTH_BLK     = aes_timing_pkg::DEPTH_BLK,
  parameter int TIMEOUT       = aes_timing_pkg::FRAME_PERIOD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [WORD_W-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic              out_last,
  output logic [1:0]        blk_count,
  output logic              overflow_err,
  output logic              timeout_err,
  output logic              frame_err
);
  import aes_timing_pkg::*;

  localparam int IDX_W = $clog2(WORDS_PER_BLK);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLK - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);

  wr_state_e        state_q, state_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d, buf_wr_idx;
  logic [TMR_W-1:0] timer_q, timer_d, timer_inc;
  logic             overflow_q, overflow_d, timeout_q, timeout_d, frame_q, frame_d;
  logic             buf_we, commit, free, xfer, full_post;
  logic [WORD_W-1:0] rd_data;

  assign out_valid = (blk_count != 2'd0);
  assign out_last  = out_valid && (rd_idx_q == LAST_IDX);
  assign out_word  = out_valid ? rd_data : '0;
  assign xfer      = out_valid && out_ready;
  assign free      = xfer && out_last;
  // Fullness is judged after this cycle's free so a drained slot is reusable immediately.
  assign full_post = (blk_count == 2'(DEPTH_BLK)) && !free;
  assign timer_inc = timer_q + 1'b1;

  assign overflow_err = overflow_q;
  assign timeout_err  = timeout_q;
  assign frame_err    = frame_q;

  always_comb begin
    state_d    = state_q;
    wr_idx_d   = wr_idx_q;
    timer_d    = timer_q;
    overflow_d = overflow_q;
    timeout_d  = timeout_q;
    frame_d    = frame_q;
    buf_we     = 1'b0;
    buf_wr_idx = wr_idx_q;
    commit     = 1'b0;
    if (in_valid && in_sof) begin
      buf_wr_idx = '0;
      wr_idx_d   = IDX_W'(1);
      timer_d    = TMR_W'(1);
      if (!full_post) begin
        buf_we  = 1'b1;
        state_d = COLLECT;
      end else begin
        overflow_d = 1'b1;
        state_d    = DROP;
      end
      if (state_q == COLLECT || (state_q == DROP && !full_post)) frame_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (in_valid) frame_d = 1'b1;
        COLLECT, DROP: begin
          if (in_valid && wr_idx_q == LAST_IDX) begin
            // Commit takes priority over a timer expiring on the same cycle.
            buf_we   = (state_q == COLLECT);
            commit   = (state_q == COLLECT);
            state_d  = IDLE;
            wr_idx_d = '0;
            timer_d  = '0;
          end else if (timer_inc == TMR_MAX) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
            wr_idx_d  = '0;
            timer_d   = '0;
          end else begin
            timer_d = timer_inc;
            if (in_valid) begin
              buf_we   = (state_q == COLLECT);
              wr_idx_d = wr_idx_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    rd_idx_d = rd_idx_q;
    if (xfer) rd_idx_d = out_last ? '0 : rd_idx_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      timer_q    <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      timer_q    <= timer_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
      frame_q    <= frame_d;
    end
  end

  blk_buffer #(
    .W    (WORD_W),
    .WPB  (WORDS_PER_BLK),
    .DEPTH(DEPTH_BLK)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .we       (buf_we),
    .wr_idx   (buf_wr_idx),
    .wr_data  (in_word),
    .commit   (commit),
    .free     (free),
    .rd_idx   (rd_idx_q),
    .rd_data  (rd_data),
    .blk_count(blk_count)
  );
endmodule

// File: doc/out_store_timing.md
Name: out_store_timing

Overview:
- Output-side counterpart of the AES input fetch/timing block.
- Collects the 32-bit ciphertext columns the AES core emits, one per cycle, and assembles them into 128-bit blocks in a small block buffer.
- Drains blocks word-by-word to the downstream consumer over a valid/ready handshake.
- Detects framing, overflow and timeout faults on the core side.

Parameters:
- WORD_W, 32: width of one column word.
- WORDS_PER_BLK, 4: words per AES block.
- DEPTH_BLK, 2: number of complete blocks the buffer holds.
- TIMEOUT, 40: max cycles from accepting word 0 to accepting the last word; equals the fetch period.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous reset, active-low.
- in_valid  in  1  core presents a column word this cycle.
- in_sof  in  1  qualifies in_valid; word is column 0 of a new block.
- in_word  in  WORD_W  ciphertext column.
- out_valid  out  1  out_word holds a buffered word.
- out_ready  in  1  consumer accepts out_word this cycle.
- out_word  out  WORD_W  current word of the head block.
- out_last  out  1  out_word is the final word of its block.
- blk_count  out  2  complete blocks stored, 0..DEPTH_BLK.
- overflow_err  out  1  sticky; a block was dropped because the buffer was full.
- timeout_err  out  1  sticky; a partial block was discarded on timeout.
- frame_err  out  1  sticky; in_sof arrived mid-block, or a word arrived without in_sof while IDLE.

Behaviour:
- Reset (rst=0 at posedge):
  - out_valid, out_last, out_word, blk_count and all three error flags go to 0.
  - Write FSM goes to IDLE; wr_idx, rd_idx and timeout counter go to 0; pointers go to 0.
  - Buffer contents are don't-care.
  - A reset mid-block or mid-drain discards everything.
- Write FSM states: IDLE, COLLECT, DROP.
- IDLE:
  - in_valid&in_sof with blk_count<DEPTH_BLK (after any same-cycle free): store word at index 0, wr_idx=1, timer=1, go to COLLECT.
  - in_valid&in_sof with the buffer full: set overflow_err, wr_idx=1, go to DROP.
  - in_valid without in_sof: word ignored, set frame_err.
- COLLECT:
  - in_valid without in_sof: store at wr_idx, wr_idx+1.
  - On storing index WORDS_PER_BLK-1: commit the block, go to IDLE. blk_count increments on that same posedge, so out_valid may rise one cycle after the last word.
  - in_valid&in_sof: discard the partial block, set frame_err, treat the word as column 0 of a new block (same rules as IDLE).
  - Timer increments every cycle. When timer reaches TIMEOUT with no commit: discard the partial, set timeout_err, go to IDLE.
  - The timer counts every cycle. A commit on the same cycle the timer would expire wins.
- DROP:
  - Same word counting, but nothing is written.
  - After the last word, return to IDLE.
  - Timeout and sof rules as in COLLECT, except a sof in DROP sets no frame_err when the buffer is still full.
- Read side:
  - out_valid = (blk_count>0).
  - out_word = buffer[rd_ptr][rd_idx]. out_last = out_valid & (rd_idx==WORDS_PER_BLK-1).
  - Transfer when out_valid&out_ready: rd_idx increments. On out_last transfer, rd_idx=0, rd_ptr advances, block freed.
  - out_word stays stable while out_valid&!out_ready.
- Commit and free on the same posedge: blk_count is unchanged, pointers both advance.
- A free on cycle N makes that slot available to a sof on cycle N itself; the full check uses post-free occupancy.
- Pointers wrap modulo DEPTH_BLK.
- Error flags are sticky until reset.

Decomposition:
- Shared package aes_timing_pkg holds:
  - WORD_W, WORDS_PER_BLK, the 40-cycle frame period constant (shared with the input timing block);
  - the write-FSM state enum {IDLE, COLLECT, DROP}.
- One sub-module, blk_buffer: DEPTH_BLK x WORDS_PER_BLK word storage.
  - Write port: ptr, idx, data, we. Read port: ptr, idx.
  - Owns the write/read pointers, blk_count, and commit/free.
- Top module holds the write FSM, timeout counter, read index and error flags.

Test Plan:
- Basic block: after reset, words A0..A3 (0x00112233..0x33445566) on 4 consecutive cycles with sof on A0, out_ready=1 -> out_valid rises the cycle after A3; A0..A3 out on 4 cycles with out_last on A3; blk_count returns to 0; no error flags.
- Backpressure/overflow: out_ready=0, send 3 blocks -> blk_count=2 and overflow_err=1 on block 3's sof. Then raise out_ready -> exactly 8 words out (blocks 1, 2), last on words 4 and 8.
- Timeout: sof+3 words then silence -> timeout_err=1 on the cycle the timer reaches 40 (40th cycle after word 0). blk_count stays 0. A following full block is delivered intact.
- Framing: sof, 2 words, then sof with B0..B3 -> frame_err=1; only B0..B3 output. A word without sof in IDLE -> frame_err=1, nothing stored.
- Simultaneous commit/free: buffer holds 1 block being drained; a new block's last word lands on the same posedge as the head's out_last transfer -> blk_count stays 1, new block drains next.
- Reset mid-operation: rst=0 during word 2 of a block and during a drain -> next cycle out_valid=0, blk_count=0, flags=0. A fresh block then passes normally.
